booth_issue_ctrl: RTL and testbench

Operand issue and result-capture controller placed directly upstream of the `booths_algo` sequential multiplier. It accepts signed operand pairs on a valid/ready input channel and drives the multiplier's load strobe and operands. It waits the multiplier's fixed iteration count, captures the 2N-bit product, and presents it on a valid/ready output channel. It turns the free-running multiplier into a flow-controlled stage with no dependence on testbench delays.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booths_algo.sv | 48 ++++
 rtl/booth_issue_ctrl.sv | 90 +++++++++
 tb/tb_booth_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier issue controller, the multiplier
// and their benches.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } booth_state_e;

    localparam int BOOTH_N = 4;

    // Cycles from the multiplier load strobe until its product is stable.
    function automatic int booth_run_cyc(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/booths_algo.sv
// Radix-2 Booth sequential multiplier: synchronous load on rst, then one
// add/shift step per cycle; out holds the signed product once N steps are done.
module booths_algo #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [N-1:0]   mr_in,
    input  logic signed [N-1:0]   md,
    output logic signed [2*N-1:0] out
);

    localparam int CW = $clog2(N + 1);

    // One guard bit on the accumulator so a most-negative multiplicand cannot overflow.
    logic signed [N:0] a_q;
    logic signed [N:0] m_q;
    logic signed [N:0] a_sum;
    logic [N-1:0]      q_q;
    logic              q1_q;
    logic [CW-1:0]     cnt_q;

    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            m_q   <= {md[N-1], md};
            q_q   <= mr_in;
            q1_q  <= 1'b0;
            cnt_q <= CW'(N);
        end else if (cnt_q != '0) begin
            a_q   <= {a_sum[N], a_sum[N:1]};
            q_q   <= {a_sum[0], q_q[N-1:1]};
            q1_q  <= q_q[0];
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign out = {a_q[N-1:0], q_q};

endmodule

// File: rtl/booth_issue_ctrl.sv
// Flow-controlled issue/capture stage around the booths_algo multiplier:
// accept an operand pair, pulse the load, wait RUN_CYC cycles, hold the product.
module booth_issue_ctrl
    import booth_pkg::*;
#(
    parameter int N       = BOOTH_N,
    parameter int RUN_CYC = booth_run_cyc(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_mr,
    input  logic signed [N-1:0]   in_md,
    output logic                  mul_load,
    output logic signed [N-1:0]   mul_mr,
    output logic signed [N-1:0]   mul_md,
    input  logic signed [2*N-1:0] mul_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N-1:0] out_prod,
    output logic                  busy
);

    localparam int            CW       = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RUN_CYC - 1);

    booth_state_e         state_q;
    booth_state_e         state_d;
    logic [CW-1:0]        cnt_q;
    logic signed [N-1:0]  op_mr_q;
    logic signed [N-1:0]  op_md_q;
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A handoff and a new accept in the same HOLD cycle go straight to LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = HOLD;
            HOLD: begin
                if (accept)         state_d = LOAD;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        mul_load  = (state_q == LOAD);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_mr_q  <= '0;
            op_md_q  <= '0;
            out_prod <= '0;
        end else begin
            if (accept) begin
                op_mr_q <= in_mr;
                op_md_q <= in_md;
            end
            case (state_q)
                LOAD: cnt_q <= CNT_INIT;
                RUN: begin
                    if (cnt_q != '0) cnt_q    <= cnt_q - CW'(1);
                    else             out_prod <= mul_out;
                end
                default: ;
            endcase
        end
    end

    // Operand registers only change on accept, so the multiplier sees stable inputs.
    assign mul_mr = op_mr_q;
    assign mul_md = op_md_q;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Scoreboard bench: booth_issue_ctrl driving booths_algo back to back.
module tb_booth_issue_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_mr;
    logic [N-1:0]   in_md;
    logic           mul_load;
    logic [N-1:0]   mul_mr;
    logic [N-1:0]   mul_md;
    logic [2*N-1:0] mul_out;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_prod;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ld_len   = 0;
    int handoffs = 0;
    int idle_seen = 0;
    bit b2b_mode = 1'b0;
    bit ov_prev  = 1'b0;

    logic [2*N-1:0] exp_q[$];
    int             acc_q[$];
    int             rise_q[$];

    booth_issue_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mr     (in_mr),
        .in_md     (in_md),
        .mul_load  (mul_load),
        .mul_mr    (mul_mr),
        .mul_md    (mul_md),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    booths_algo #(.N(N)) u_mul (
        .clk   (clk),
        .rst   (mul_load),
        .mr_in (mul_mr),
        .md    (mul_md),
        .out   (mul_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: scoreboard pops, latency, load pulse width, idle gaps.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (mul_load) ld_len++;
            else if (ld_len != 0) begin
                chk("load_pulse_len", 32'(ld_len), 32'd1);
                ld_len = 0;
            end
            if (out_valid && !ov_prev) begin
                rise_q.push_back(cyc);
                if (acc_q.size() == 0) fail("valid_without_accept");
                else chk("accept_to_valid_latency", 32'(cyc - acc_q.pop_front()), 32'd6);
            end
            if (out_valid && out_ready) begin
                handoffs++;
                if (exp_q.size() == 0) fail("unexpected_product");
                else chk("product", 32'(out_prod), 32'(exp_q.pop_front()));
            end
            if (b2b_mode && !busy) idle_seen++;
        end
        ov_prev = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [N-1:0] mr, input logic [N-1:0] md,
                        input logic [2*N-1:0] exp, input bit keep);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        in_mr = mr;
        in_md = md;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end else if (++t > 200) begin
                fail("accept_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid) begin
            if (++t > max_cyc) begin
                fail("out_valid_timeout");
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || busy) begin
            if (++t > 100) begin
                fail("drain_timeout");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mr = '0;
        in_md = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_load", 32'(mul_load), 32'd0);
        chk("rst_mul_mr", 32'(mul_mr), 32'd0);
        chk("rst_mul_md", 32'(mul_md), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_prod", 32'(out_prod), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 7 * 5, then back to IDLE right after the handoff
        out_ready = 1'b1;
        send(4'd7, 4'd5, 8'd35, 1'b0);
        wait_valid(20);
        @(negedge clk);
        chk("idle_after_handoff_busy", 32'(busy), 32'd0);
        chk("idle_after_handoff_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // signed cases: 3 * -5 and -8 * -8
        send(4'd3, 4'b1011, 8'hF1, 1'b0);
        drain();
        send(4'b1000, 4'b1000, 8'd64, 1'b0);
        drain();

        // backpressure: 2 * -3 held for 10 cycles with a pending input ignored
        out_ready = 1'b0;
        send(4'd2, 4'b1101, 8'hFA, 1'b0);
        wait_valid(20);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_mr = 4'd1;
        in_md = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_prod", 32'(out_prod), 32'hFA);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int h0;
            h0 = handoffs;
            out_ready = 1'b1;
            repeat (3) @(negedge clk);
            chk("bp_single_handoff", 32'(handoffs - h0), 32'd1);
            chk("bp_idle_after", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // back-to-back: 7*5, 3*-5, -1*-1 with in_valid and out_ready high
        rise_q.delete();
        idle_seen = 0;
        send(4'd7, 4'd5, 8'd35, 1'b1);
        b2b_mode = 1'b1;
        send(4'd3, 4'b1011, 8'hF1, 1'b1);
        send(4'b1111, 4'b1111, 8'd1, 1'b0);
        wait_valid(20);
        b2b_mode = 1'b0;
        drain();
        chk("b2b_no_idle_gap", 32'(idle_seen), 32'd0);
        chk("b2b_rise_count", 32'(rise_q.size()), 32'd3);
        if (rise_q.size() == 3) begin
            chk("b2b_interval_1", 32'(rise_q[1] - rise_q[0]), 32'd7);
            chk("b2b_interval_2", 32'(rise_q[2] - rise_q[1]), 32'd7);
        end

        // asynchronous reset in the middle of RUN discards the product
        send(4'd7, 4'd5, 8'd35, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mul_load", 32'(mul_load), 32'd0);
        chk("async_rst_mul_mr", 32'(mul_mr), 32'd0);
        chk("async_rst_mul_md", 32'(mul_md), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_prod", 32'(out_prod), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("no_product_after_reset", 32'(seen), 32'd0);
        end
        @(posedge clk);
        #1;
        send(4'd3, 4'd3, 8'd9, 1'b0);
        drain();

        // in_valid toggled while busy must not disturb operands or product
        send(4'd6, 4'b1110, 8'hF4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = (i % 2 == 0);
            in_mr = 4'd5;
            in_md = 4'd5;
            @(negedge clk);
            chk("busy_mul_mr_held", 32'(mul_mr), 32'h6);
            chk("busy_mul_md_held", 32'(mul_md), 32'hE);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
